gp_fifo: RTL and testbench
==========================

Name: gp_fifo

Overview:
General-purpose synchronous single-clock FIFO used as the buffering element in the network interface and router datapaths. It stores up to LENGTH words of DEPTH bits, with registered read data. It reports full, empty and occupancy, and flags illegal accesses: overflow writes and underflow reads.

Parameters:
LENGTH, 32, number of storage slots; must be a power of two, ≥2.
DEPTH, 32, data word width in bits. The name is historical; it means width, not slot count.
MSB_SLOT, 5, equals log2(LENGTH); ocup is MSB_SLOT+1 bits so it can hold the value LENGTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
write_en  input  1  write request for this cycle.
read_en  input  1  read request for this cycle.
data_in  input  DEPTH  write data, sampled on the rising edge when the write is accepted.
data_out  output  DEPTH  registered read data.
error  output  1  registered illegal-access flag, valid for one cycle.
full  output  1  high when ocup == LENGTH.
empty  output  1  high when ocup == 0.
ocup  output  MSB_SLOT+1  current number of stored words.

Behaviour:
- Storage: LENGTH x DEPTH array.
  - Write pointer and read pointer are each MSB_SLOT bits and wrap naturally modulo LENGTH.
  - Occupancy counter is MSB_SLOT+1 bits.
- Reset (reset low, asynchronous):
  - Pointers cleared to 0.
  - ocup = 0, data_out = 0, error = 0.
  - As a result, empty = 1 and full = 0.
  - Array contents are not reset.
  - Reset asserted mid-operation discards all stored words immediately.
- Accept rules, evaluated on each rising edge with reset high:
  - wr_ok = write_en & (!full | read_en).
  - rd_ok = read_en & !empty.
- Write accepted: mem[wr_ptr] <= data_in; wr_ptr increments.
- Read accepted:
  - data_out <= mem[rd_ptr]; rd_ptr increments.
  - Read latency is 1 cycle: data appears after the edge that sampled read_en.
  - data_out holds its last value whenever no read is accepted.
- Occupancy update:
  - ocup increments by 1 when wr_ok & !rd_ok.
  - ocup decrements by 1 when rd_ok & !wr_ok.
  - ocup is unchanged when both or neither are accepted.
- Simultaneous read+write when full: both accepted; the old head is read, the new word goes into the freed slot, and ocup stays LENGTH.
- Simultaneous read+write when empty:
  - The write is accepted and the read is rejected; there is no fall-through.
  - ocup becomes 1, data_out holds, and error is raised.
- Error flag:
  - Set to 1 for exactly the cycle following an edge where either (write_en & full & !read_en) or (read_en & empty) was sampled.
  - Otherwise cleared to 0 on the next edge. It is not sticky.
  - A rejected write leaves the array, pointers and ocup unchanged.
  - A rejected read leaves data_out and rd_ptr unchanged.
- full, empty: combinational decodes of the registered ocup; no extra latency.
- Pointer wrap: slot LENGTH-1 is followed by slot 0; ordering is strictly first-in first-out across the wrap.
- No X propagation from the unreset array: data_out only loads from slots that were previously written.

Test Plan:
- Reset and basic order:
  - Hold reset low for 1 cycle -> ocup=0, empty=1, full=0, data_out=0, error=0.
  - Release reset, then write 0x0101A5A5, 0x0000BBBB, 0x00010001 on consecutive cycles -> ocup=3, empty=0.
- Read and simultaneous read/write:
  - Read once -> data_out=0x0101A5A5, ocup=2.
  - Next cycle, read and write 0x0100CCCC together -> data_out=0x0000BBBB, ocup=2.
  - Two further reads -> data_out=0x00010001 then 0x0100CCCC, ocup=0, empty=1.
- Fill and overflow:
  - From empty, write 32 words 0..31 -> full=1, ocup=32.
  - A 33rd write alone -> error=1 for one cycle, ocup stays 32.
  - Draining yields 0..31 in order.
- Full with read+write: when full, read_en and write_en together with data 0xDEADBEEF -> ocup stays 32, error=0; 0xDEADBEEF emerges as the last word of the drain.
- Underflow:
  - Read when empty -> error=1 for one cycle, data_out holds its previous value, ocup=0.
  - Read plus write 0x12345678 while empty -> error=1, ocup=1; a following read returns 0x12345678.
- Wrap-around and mid-operation reset:
  - Perform 40 interleaved write/read pairs -> output sequence matches input across the pointer wrap.
  - Assert reset asynchronously between edges with ocup=5 -> ocup=0, empty=1, data_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/gp_fifo.sv
// gp_fifo: single-clock synchronous FIFO with registered read data.
// Tracks occupancy, decodes full/empty from it, and raises a one-cycle
// error pulse on an overflow write or underflow read. The storage array
// is never reset; data_out only ever loads from slots that were written.
module gp_fifo #(
   parameter int LENGTH   = 32,  // slot count, power of two, >= 2
   parameter int DEPTH    = 32,  // word width in bits (historical name)
   parameter int MSB_SLOT = 5    // log2(LENGTH)
) (
   input  logic                clk,
   input  logic                reset,     // asynchronous, active low
   input  logic                write_en,
   input  logic                read_en,
   input  logic [DEPTH-1:0]    data_in,
   output logic [DEPTH-1:0]    data_out,
   output logic                error,
   output logic                full,
   output logic                empty,
   output logic [MSB_SLOT:0]   ocup
);

   localparam logic [MSB_SLOT:0]   OCUP_FULL = (MSB_SLOT+1)'(LENGTH);
   localparam logic [MSB_SLOT:0]   OCUP_ONE  = (MSB_SLOT+1)'(1);
   localparam logic [MSB_SLOT-1:0] PTR_ONE   = (MSB_SLOT)'(1);

   logic [DEPTH-1:0]    mem [LENGTH];
   logic [MSB_SLOT-1:0] wr_ptr_reg;
   logic [MSB_SLOT-1:0] rd_ptr_reg;
   logic [MSB_SLOT:0]   ocup_reg;
   logic [DEPTH-1:0]    data_out_reg;
   logic                error_reg;

   logic                wr_ok;
   logic                rd_ok;
   logic                error_next;

   assign full     = (ocup_reg == OCUP_FULL);
   assign empty    = (ocup_reg == '0);
   assign ocup     = ocup_reg;
   assign data_out = data_out_reg;
   assign error    = error_reg;

   // Accept decisions; a write into a full FIFO is allowed when a read frees the head slot.
   always_comb begin
      wr_ok      = write_en & (~full | read_en);
      rd_ok      = read_en & ~empty;
      error_next = (write_en & full & ~read_en) | (read_en & empty);
   end

   // Storage array write port; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   // Pointers, occupancy, registered read data and the one-cycle error pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         ocup_reg     <= '0;
         data_out_reg <= '0;
         error_reg    <= 1'b0;
      end else begin
         error_reg <= error_next;
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (rd_ok) begin
            data_out_reg <= mem[rd_ptr_reg];
            rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   ocup_reg <= ocup_reg + OCUP_ONE;
            2'b01:   ocup_reg <= ocup_reg - OCUP_ONE;
            default: ocup_reg <= ocup_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_gp_fifo.sv
// Testbench for gp_fifo: directed stimulus pushes the expected post-edge
// state into a scoreboard queue; a negedge monitor pops and compares.
module tb_gp_fifo;

   logic        clk;
   logic        reset;
   logic        write_en;
   logic        read_en;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        error;
   logic        full;
   logic        empty;
   logic [5:0]  ocup;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [31:0] data;
      logic [5:0]  ocup;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cycle = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_rd;

   gp_fifo #(.LENGTH(32), .DEPTH(32), .MSB_SLOT(5)) dut (
      .clk(clk),
      .reset(reset),
      .write_en(write_en),
      .read_en(read_en),
      .data_in(data_in),
      .data_out(data_out),
      .error(error),
      .full(full),
      .empty(empty),
      .ocup(ocup)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the expectation targets the state after the next rising edge.
   task automatic step(input string name, input logic we, input logic re, input logic [31:0] din,
                       input logic [31:0] e_data, input logic [5:0] e_ocup, input logic e_err);
      exp_t e;
      @(posedge clk);
      #1;
      write_en = we;
      read_en  = re;
      data_in  = din;
      e.cyc  = cycle + 1;
      e.name = name;
      e.data = e_data;
      e.ocup = e_ocup;
      e.err  = e_err;
      sb_q.push_back(e);
   endtask

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
         exp_t e;
         e = sb_q.pop_front();
         chk({e.name, "_cycle"}, e.cyc, cycle);
         chk({e.name, "_data"}, data_out, e.data);
         chk({e.name, "_ocup"}, 32'(ocup), 32'(e.ocup));
         chk({e.name, "_err"}, 32'(error), 32'(e.err));
         chk({e.name, "_full"}, 32'(full), 32'(e.ocup == 6'd32));
         chk({e.name, "_empty"}, 32'(empty), 32'(e.ocup == 6'd0));
         $display("txn %-10s data_out=%h ocup=%0d err=%0d", e.name, data_out, ocup, error);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b0;
      write_en = 1'b0;
      read_en  = 1'b0;
      data_in  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ocup", 32'(ocup), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_data", data_out, 0);
      chk("rst_err", 32'(error), 0);
      reset = 1'b1;

      // Basic ordering and simultaneous read/write
      step("wr1", 1, 0, 32'h0101A5A5, 32'h0, 6'd1, 0);
      step("wr2", 1, 0, 32'h0000BBBB, 32'h0, 6'd2, 0);
      step("wr3", 1, 0, 32'h00010001, 32'h0, 6'd3, 0);
      step("rd1", 0, 1, 32'h0, 32'h0101A5A5, 6'd2, 0);
      step("rw1", 1, 1, 32'h0100CCCC, 32'h0000BBBB, 6'd2, 0);
      step("rd2", 0, 1, 32'h0, 32'h00010001, 6'd1, 0);
      step("rd3", 0, 1, 32'h0, 32'h0100CCCC, 6'd0, 0);

      // Fill to full, then overflow
      for (int i = 0; i < 32; i++)
         step($sformatf("fill%0d", i), 1, 0, 32'(i), 32'h0100CCCC, 6'(i + 1), 0);
      step("ovf", 1, 0, 32'h99, 32'h0100CCCC, 6'd32, 1);
      step("ovf_clr", 0, 0, 32'h0, 32'h0100CCCC, 6'd32, 0);

      // Read+write while full, then drain
      step("rw_full", 1, 1, 32'hDEADBEEF, 32'h0, 6'd32, 0);
      for (int i = 1; i < 32; i++)
         step($sformatf("drain%0d", i), 0, 1, 32'h0, 32'(i), 6'(32 - i), 0);
      step("drain_last", 0, 1, 32'h0, 32'hDEADBEEF, 6'd0, 0);

      // Underflow and read+write while empty
      step("udf", 0, 1, 32'h0, 32'hDEADBEEF, 6'd0, 1);
      step("udf_clr", 0, 0, 32'h0, 32'hDEADBEEF, 6'd0, 0);
      step("rw_empty", 1, 1, 32'h12345678, 32'hDEADBEEF, 6'd1, 1);
      step("rd_after", 0, 1, 32'h0, 32'h12345678, 6'd0, 0);

      // Interleaved pairs across the pointer wrap
      last_rd = 32'h12345678;
      for (int i = 0; i < 40; i++) begin
         step($sformatf("wrap_w%0d", i), 1, 0, 32'hA000 + 32'(i), last_rd, 6'd1, 0);
         step($sformatf("wrap_r%0d", i), 0, 1, 32'h0, 32'hA000 + 32'(i), 6'd0, 0);
         last_rd = 32'hA000 + 32'(i);
      end

      // Load five words, then reset between edges
      for (int i = 0; i < 5; i++)
         step($sformatf("pre_rst%0d", i), 1, 0, 32'hB000 + 32'(i), last_rd, 6'(i + 1), 0);
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_ocup", 32'(ocup), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_data", data_out, 0);
      chk("arst_err", 32'(error), 0);
      @(negedge clk);
      reset = 1'b1;

      // Stored words were discarded
      step("post_udf", 0, 1, 32'h0, 32'h0, 6'd0, 1);
      step("post_wr", 1, 0, 32'h00005555, 32'h0, 6'd1, 0);
      step("post_rd", 0, 1, 32'h0, 32'h00005555, 6'd0, 0);
      step("post_idle", 0, 0, 32'h0, 32'h00005555, 6'd0, 0);

      repeat (3) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
